lcd_timing_gen: RTL and testbench

- Parametrised LCD/VGA timing generator and pixel-fetch front end.
- Successor to the fixed-mode LCD driver: every timing field, data width and request lead is a parameter.
- Adds frame-boundary start/stop control, registered glitch-free outputs, per-polarity sync, and frame/line strobes.
- Sits between the SDRAM read FIFO (pixel source) and the VGA DAC/LCD pins.

---
 rtl/lcd_timing_gen.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA timing generator and pixel-fetch front end with registered outputs.
// Build macro TEST_PATTERN_EN adds the pattern_sel input and an 8-bar colour test pattern.
module lcd_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DATA_W   = 16,
    parameter int REQ_LEAD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_on,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    input  logic [DATA_W-1:0] lcd_data,
    output logic              lcd_dclk,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_blank,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              lcd_request,
    output logic [10:0]       lcd_xpos,
    output logic [10:0]       lcd_ypos,
    output logic              frame_start,
    output logic              line_start,
    output logic              running
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("lcd_timing_gen: H_TOTAL or V_TOTAL exceeds 2048");
    end
    if (REQ_LEAD < 1 || REQ_LEAD > 4 || H_BACK < REQ_LEAD) begin : g_bad_lead
        $error("lcd_timing_gen: REQ_LEAD must be 1..4 and not exceed H_BACK");
    end

    localparam logic [11:0] HS_END = 12'(H_SYNC);
    localparam logic [11:0] HA_BEG = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HA_END = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VS_END = 12'(V_SYNC);
    localparam logic [11:0] VA_BEG = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VA_END = 12'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [11:0] LEAD   = 12'(REQ_LEAD);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_next;
    logic [10:0] r_hcnt, r_vcnt, w_hcnt_next, w_vcnt_next;

    logic              r_hs, r_vs, r_blank, r_de, r_req, r_frame_start, r_line_start, r_running;
    logic [DATA_W-1:0] r_rgb;
    logic [10:0]       r_xpos, r_ypos;

    logic              w_run, w_hs_act, w_vs_act, w_v_act, w_de, w_req, w_req_en;
    logic [11:0]       w_h, w_v, w_hl;
    logic [DATA_W-1:0] w_pixel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
            r_vcnt  <= w_vcnt_next;
        end
    end

    // Stopping is only allowed on the last clock of a frame, so a frame is never cut short.
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        w_vcnt_next  = r_vcnt;
        case (r_state)
            S_IDLE: begin
                w_hcnt_next = '0;
                w_vcnt_next = '0;
                if (disp_on) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (r_hcnt == H_LAST) begin
                    w_hcnt_next = '0;
                    if (r_vcnt == V_LAST) begin
                        w_vcnt_next = '0;
                        if (!disp_on) w_state_next = S_IDLE;
                    end else begin
                        w_vcnt_next = r_vcnt + 11'd1;
                    end
                end else begin
                    w_hcnt_next = r_hcnt + 11'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_run    = (r_state == S_RUN);
    assign w_h      = {1'b0, r_hcnt};
    assign w_v      = {1'b0, r_vcnt};
    assign w_hl     = w_h + LEAD;
    assign w_hs_act = w_run && (w_h < HS_END);
    assign w_vs_act = w_run && (w_v < VS_END);
    assign w_v_act  = w_run && (w_v >= VA_BEG) && (w_v < VA_END);
    assign w_de     = w_v_act && (w_h >= HA_BEG) && (w_h < HA_END);
    // The fetch window is the active window shifted REQ_LEAD clocks earlier on the same line.
    assign w_req    = w_v_act && w_req_en && (w_hl >= HA_BEG) && (w_hl < HA_END);

`ifdef TEST_PATTERN_EN
    localparam int R_W = DATA_W / 3;
    localparam int B_W = DATA_W / 3;
    localparam int G_W = DATA_W - R_W - B_W;

    logic              r_pattern;
    logic [11:0]       w_col;
    logic [2:0]        w_bar;
    logic [DATA_W-1:0] w_bar_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_pattern <= 1'b0;
        else if (w_run && r_hcnt == '0 && r_vcnt == '0) r_pattern <= pattern_sel;
    end

    assign w_col = w_h - HA_BEG;
    assign w_bar = 3'(({3'b000, w_col} * 15'd8) / 15'(H_DISP));

    // Bars: white, yellow, cyan, green, magenta, red, blue, black as {R,G,B} on/off.
    always_comb begin
        logic [2:0] w_on;
        case (w_bar)
            3'd0:    w_on = 3'b111;
            3'd1:    w_on = 3'b110;
            3'd2:    w_on = 3'b011;
            3'd3:    w_on = 3'b010;
            3'd4:    w_on = 3'b101;
            3'd5:    w_on = 3'b100;
            3'd6:    w_on = 3'b001;
            default: w_on = 3'b000;
        endcase
        w_bar_rgb = {{R_W{w_on[2]}}, {G_W{w_on[1]}}, {B_W{w_on[0]}}};
    end

    assign w_req_en = !r_pattern;
    assign w_pixel  = r_pattern ? w_bar_rgb : lcd_data;
`else
    assign w_req_en = 1'b1;
    assign w_pixel  = lcd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs          <= !HS_POL;
            r_vs          <= !VS_POL;
            r_blank       <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_req         <= 1'b0;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_hs          <= w_hs_act ? HS_POL : !HS_POL;
            r_vs          <= w_vs_act ? VS_POL : !VS_POL;
            r_blank       <= !(w_hs_act || w_vs_act);
            r_de          <= w_de;
            r_rgb         <= w_de ? w_pixel : '0;
            r_req         <= w_req;
            r_xpos        <= w_req ? 11'(w_hl - HA_BEG) : '0;
            r_ypos        <= w_req ? 11'(w_v - VA_BEG) : '0;
            r_frame_start <= w_run && (r_hcnt == '0) && (r_vcnt == '0);
            r_line_start  <= w_run && (r_hcnt == '0);
            r_running     <= (w_state_next == S_RUN);
        end
    end

    assign lcd_dclk    = ~clk;
    assign lcd_hs      = r_hs;
    assign lcd_vs      = r_vs;
    assign lcd_blank   = r_blank;
    assign lcd_de      = r_de;
    assign lcd_rgb     = r_rgb;
    assign lcd_request = r_req;
    assign lcd_xpos    = r_xpos;
    assign lcd_ypos    = r_ypos;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign running     = r_running;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: small timing config, two instances (lead 3 / low-active sync,
// lead 1 / high-active sync) checked every clock against a frame-position reference model.
module tb_lcd_timing_gen;
    localparam int H_S = 2, H_B = 3, H_D = 8, H_F = 2;
    localparam int V_S = 1, V_B = 2, V_D = 4, V_F = 1;
    localparam int H_T = H_S + H_B + H_D + H_F;
    localparam int V_T = V_S + V_B + V_D + V_F;
    localparam int F_T = H_T * V_T;
    localparam int HA0 = H_S + H_B;
    localparam int VA0 = V_S + V_B;

    typedef struct packed {
        logic        hs, vs, blank, de, req, fs, ls, run;
        logic [15:0] rgb;
        logic [10:0] x, y;
    } out_t;

    typedef struct {
        logic        req;
        logic [10:0] x, y;
    } rq_t;

    typedef struct {
        logic disp;
        int   cycles;
        int   fs, ls, de, req, hs_low, vs_low;
        logic run_end;
        logic collect;
    } row_t;

    logic clk, rst_n, disp_on, chk_en;
    logic [15:0] a_data, b_data, c_data;
    logic a_dclk, a_hs, a_vs, a_blank, a_de, a_req, a_fs, a_ls, a_run;
    logic b_dclk, b_hs, b_vs, b_blank, b_de, b_req, b_fs, b_ls, b_run;
    logic [15:0] a_rgb, b_rgb;
    logic [10:0] a_x, a_y, b_x, b_y;
    out_t a_o, b_o, e_a, e_b;

    int n_checks = 0;
    int n_errors = 0;
    int m_pos = -1;
    int m_out_pos = -1;

    lcd_timing_gen #(
        .H_SYNC(H_S), .H_BACK(H_B), .H_DISP(H_D), .H_FRONT(H_F),
        .V_SYNC(V_S), .V_BACK(V_B), .V_DISP(V_D), .V_FRONT(V_F),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(16), .REQ_LEAD(3)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .disp_on(disp_on),
`ifdef TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .lcd_data(a_data), .lcd_dclk(a_dclk), .lcd_hs(a_hs), .lcd_vs(a_vs),
        .lcd_blank(a_blank), .lcd_de(a_de), .lcd_rgb(a_rgb), .lcd_request(a_req),
        .lcd_xpos(a_x), .lcd_ypos(a_y), .frame_start(a_fs), .line_start(a_ls),
        .running(a_run)
    );

    lcd_timing_gen #(
        .H_SYNC(H_S), .H_BACK(H_B), .H_DISP(H_D), .H_FRONT(H_F),
        .V_SYNC(V_S), .V_BACK(V_B), .V_DISP(V_D), .V_FRONT(V_F),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(16), .REQ_LEAD(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .disp_on(disp_on),
`ifdef TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .lcd_data(b_data), .lcd_dclk(b_dclk), .lcd_hs(b_hs), .lcd_vs(b_vs),
        .lcd_blank(b_blank), .lcd_de(b_de), .lcd_rgb(b_rgb), .lcd_request(b_req),
        .lcd_xpos(b_x), .lcd_ypos(b_y), .frame_start(b_fs), .line_start(b_ls),
        .running(b_run)
    );

`ifdef TEST_PATTERN_EN
    logic c_dclk, c_hs, c_vs, c_blank, c_de, c_req, c_fs, c_ls, c_run;
    logic [15:0] c_rgb;
    logic [10:0] c_x, c_y;
    logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    lcd_timing_gen #(
        .H_SYNC(H_S), .H_BACK(H_B), .H_DISP(H_D), .H_FRONT(H_F),
        .V_SYNC(V_S), .V_BACK(V_B), .V_DISP(V_D), .V_FRONT(V_F),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(16), .REQ_LEAD(1)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .disp_on(disp_on), .pattern_sel(1'b1),
        .lcd_data(c_data), .lcd_dclk(c_dclk), .lcd_hs(c_hs), .lcd_vs(c_vs),
        .lcd_blank(c_blank), .lcd_de(c_de), .lcd_rgb(c_rgb), .lcd_request(c_req),
        .lcd_xpos(c_x), .lcd_ypos(c_y), .frame_start(c_fs), .line_start(c_ls),
        .running(c_run)
    );
`endif

    assign a_o = {a_hs, a_vs, a_blank, a_de, a_req, a_fs, a_ls, a_run, a_rgb, a_x, a_y};
    assign b_o = {b_hs, b_vs, b_blank, b_de, b_req, b_fs, b_ls, b_run, b_rgb, b_x, b_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input int x, input int y);
        return 16'(x + 16 * y);
    endfunction

    // Expected pins for the clock whose registered outputs came from frame position p
    // (-1 = idle); p_now is the position the generator is at during that clock.
    function automatic out_t model_out(input int p, input int p_now, input int lead, input bit pol);
        out_t o;
        int   h, v;
        o = '0;
        o.hs    = !pol;
        o.vs    = !pol;
        o.blank = 1'b1;
        o.run   = (p_now >= 0);
        if (p >= 0) begin
            h = p % H_T;
            v = p / H_T;
            o.hs    = (h < H_S) ? pol : !pol;
            o.vs    = (v < V_S) ? pol : !pol;
            o.blank = !((h < H_S) || (v < V_S));
            o.ls    = (h == 0);
            o.fs    = (p == 0);
            if (v >= VA0 && v < VA0 + V_D) begin
                if (h >= HA0 && h < HA0 + H_D) begin
                    o.de  = 1'b1;
                    o.rgb = pix(h - HA0, v - VA0);
                end
                if (h + lead >= HA0 && h + lead < HA0 + H_D) begin
                    o.req = 1'b1;
                    o.x   = 11'(h + lead - HA0);
                    o.y   = 11'(v - VA0);
                end
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t act, input out_t exp);
        chk({tag, "_hs"},    32'(act.hs),    32'(exp.hs));
        chk({tag, "_vs"},    32'(act.vs),    32'(exp.vs));
        chk({tag, "_blank"}, 32'(act.blank), 32'(exp.blank));
        chk({tag, "_de"},    32'(act.de),    32'(exp.de));
        chk({tag, "_req"},   32'(act.req),   32'(exp.req));
        chk({tag, "_fs"},    32'(act.fs),    32'(exp.fs));
        chk({tag, "_ls"},    32'(act.ls),    32'(exp.ls));
        chk({tag, "_run"},   32'(act.run),   32'(exp.run));
        chk({tag, "_rgb"},   32'(act.rgb),   32'(exp.rgb));
        chk({tag, "_x"},     32'(act.x),     32'(exp.x));
        chk({tag, "_y"},     32'(act.y),     32'(exp.y));
    endtask

    // Frame position of the generator: starts at 0 after disp_on is seen while idle and only
    // stops (or restarts) at the end of a full frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos     <= -1;
            m_out_pos <= -1;
        end else begin
            m_out_pos <= m_pos;
            if (m_pos < 0 || m_pos == F_T - 1) m_pos <= disp_on ? 0 : -1;
            else                               m_pos <= m_pos + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_a = model_out(m_out_pos, m_pos, 3, 1'b0);
            e_b = model_out(m_out_pos, m_pos, 1, 1'b1);
            cmp_out("a", a_o, e_a);
            cmp_out("b", b_o, e_b);
            chk("a_dclk", 32'(a_dclk), 32'(!clk));
`ifdef TEST_PATTERN_EN
            begin
                int col;
                col = (m_out_pos >= 0) ? (m_out_pos % H_T) - HA0 : 0;
                chk("c_de",  32'(c_de),  32'(e_b.de));
                chk("c_req", 32'(c_req), 32'd0);
                chk("c_rgb", 32'(c_rgb), e_b.de ? 32'(bar_rgb[(col * 8) / H_D]) : 32'd0);
            end
`endif
        end
    end

    // Pixel source: answers each request on the clock REQ_LEAD-1 after it, garbage otherwise.
    initial begin
        rq_t a_hist [4];
        a_data = '0;
        b_data = '0;
        c_data = 16'hA5A5;
        for (int i = 0; i < 4; i++) a_hist[i] = '{1'b0, 11'd0, 11'd0};
        forever begin
            @(posedge clk);
            #2;
            for (int i = 3; i > 0; i--) a_hist[i] = a_hist[i-1];
            a_hist[0] = '{a_req, a_x, a_y};
            a_data = a_hist[2].req ? pix(int'(a_hist[2].x), int'(a_hist[2].y)) : 16'($urandom);
            b_data = b_req ? pix(int'(b_x), int'(b_y)) : 16'($urandom);
            c_data = 16'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t        rows [7];
        logic [15:0] rgb_q [$];
        int c_fs, c_ls, c_de, c_req, c_hs, c_vs, found, lat, activity;

        rows[0] = '{1'b0, 10,  0,  0,  0,  0,  0,  0, 1'b0, 1'b0};
        rows[1] = '{1'b1, 2,   0,  0,  0,  0,  0,  0, 1'b1, 1'b0};
        rows[2] = '{1'b1, 240, 2, 16, 64, 64, 32, 30, 1'b1, 1'b1};
        rows[3] = '{1'b1, 40,  1,  3,  0,  0,  6, 15, 1'b1, 1'b0};
        rows[4] = '{1'b0, 80,  0,  5, 32, 32, 10,  0, 1'b0, 1'b0};
        rows[5] = '{1'b0, 30,  0,  0,  0,  0,  0,  0, 1'b0, 1'b0};
        rows[6] = '{1'b1, 3,   1,  1,  0,  0,  1,  1, 1'b1, 1'b0};

        rst_n = 1'b0;
        disp_on = 1'b0;
        chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_out("rst_a", a_o, model_out(-1, -1, 3, 1'b0));
        cmp_out("rst_b", b_o, model_out(-1, -1, 1, 1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        for (int r = 0; r < 7; r++) begin
            c_fs = 0; c_ls = 0; c_de = 0; c_req = 0; c_hs = 0; c_vs = 0;
            for (int i = 0; i < rows[r].cycles; i++) begin
                @(posedge clk);
                #1;
                disp_on = rows[r].disp;
                @(negedge clk);
                if (a_fs) c_fs++;
                if (a_ls) c_ls++;
                if (a_de) c_de++;
                if (a_req) c_req++;
                if (!a_hs) c_hs++;
                if (!a_vs) c_vs++;
                if (rows[r].collect && a_de) rgb_q.push_back(a_rgb);
            end
            chk($sformatf("row%0d_fs", r),     32'(c_fs),  32'(rows[r].fs));
            chk($sformatf("row%0d_ls", r),     32'(c_ls),  32'(rows[r].ls));
            chk($sformatf("row%0d_de", r),     32'(c_de),  32'(rows[r].de));
            chk($sformatf("row%0d_req", r),    32'(c_req), 32'(rows[r].req));
            chk($sformatf("row%0d_hs_low", r), 32'(c_hs),  32'(rows[r].hs_low));
            chk($sformatf("row%0d_vs_low", r), 32'(c_vs),  32'(rows[r].vs_low));
            chk($sformatf("row%0d_run", r),    32'(a_run), 32'(rows[r].run_end));
            $display("row %0d disp_on=%0d cycles=%0d fs=%0d ls=%0d de=%0d req=%0d hs_low=%0d vs_low=%0d",
                     r, rows[r].disp, rows[r].cycles, c_fs, c_ls, c_de, c_req, c_hs, c_vs);
        end

        chk("rgb_seq_len", 32'(rgb_q.size()), 32'd64);
        for (int k = 0; k < rgb_q.size() && k < 64; k++)
            chk($sformatf("rgb_seq_%0d", k), 32'(rgb_q[k]), 32'(pix(k % 8, (k % 32) / 8)));

        // Asynchronous reset in the middle of an active line.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (a_de) found = 1;
        end
        chk("wait_active_line", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        disp_on = 1'b0;
        #1;
        cmp_out("midrst_a", a_o, model_out(-1, -1, 3, 1'b0));
        cmp_out("midrst_b", b_o, model_out(-1, -1, 1, 1'b1));
        $display("mid-line reset: a_de=%0d a_req=%0d a_rgb=%0h a_hs=%0d b_hs=%0d", a_de, a_req, a_rgb, a_hs, b_hs);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_fs || a_de || a_req || a_run || b_fs || b_de || b_req || b_run) activity++;
        end
        chk("idle_after_reset", 32'(activity), 32'd0);

        // Restart latency: frame_start two clocks after disp_on is raised.
        @(posedge clk);
        #1;
        disp_on = 1'b1;
        lat = 0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (a_fs) found = 1;
        end
        chk("restart_seen", 32'(found), 32'd1);
        chk("restart_latency", 32'(lat), 32'd2);
        $display("restart: frame_start after %0d clocks", lat);

        // Random run/stop requests, including mid-frame toggles.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 149) == 0) disp_on = ~disp_on;
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
